beat_sequencer: RTL
===================

# beat_sequencer

Beat sequencer for the step-sequencer mode. It generates the 0–7 beat index consumed by the beat-to-LED decoder, paces beats from a selectable tempo, and holds an 8-step note pattern. It plays back the stored note for the current beat. It sits between the button/edit front end and the tone generator and LED decode, and is active only while `sequencer_on` is high.

## Interface
Parameters:
- `NOTE_W`, 4: width of a stored note; note value 0 means rest.
- `BASE_TICKS`, 1_000_000: clock cycles per tempo unit; beat period P = `BASE_TICKS` × (8 − `tempo_sel`).

Ports:
- `clk`  in  1: system clock; single clock domain.
- `n_rst`  in  1: reset, synchronous, active-low.
- `sequencer_on`  in  1: 1 = sequencer mode, 0 = piano mode (forces STOP).
- `play_toggle`  in  1: one-cycle pulse; start, pause or resume.
- `stop`  in  1: one-cycle pulse; return to STOP.
- `tempo_sel`  in  3: 7 = fastest (P = `BASE_TICKS`×1), 0 = slowest (×8).
- `wr_en`  in  1: pattern write strobe.
- `wr_beat`  in  3: step to write.
- `wr_note`  in  NOTE_W: note to store.
- `beat`  out  3: current step 0–7.
- `beat_strobe`  out  1: one-cycle pulse at the first cycle of each beat while RUN.
- `note`  out  NOTE_W: `pattern[beat]`.
- `note_gate`  out  1: note should sound.
- `running`  out  1: state == RUN.

## Operation
- States are STOP, RUN and PAUSE. Reset enters STOP.
- Transition priority, highest first: `sequencer_on`=0 → STOP; `stop` → STOP; `play_toggle`.
- `play_toggle` transitions:
  - STOP → RUN, with beat=0 and cnt=0.
  - RUN → PAUSE, holding beat and cnt.
  - PAUSE → RUN, resuming from the held cnt.
- Entering STOP clears beat and cnt.
- Tick counter cnt:
  - In RUN it counts 0..P−1.
  - When cnt == P−1, the next cycle has cnt=0 and beat=beat+1 mod 8 (7 wraps to 0).
  - In STOP and PAUSE, cnt and beat are frozen.
- Tempo latch: P is latched from `tempo_sel` on STOP→RUN and on every cycle where cnt==0 in RUN. A tempo change never truncates or extends the beat already in progress.
- Pattern storage:
  - 8 × NOTE_W registers, cleared to 0 on reset.
  - Contents are retained across STOP and across mode changes.
- Pattern writes:
  - A write is accepted in any state.
  - The written value is visible on `note` from the cycle after `wr_en`.
  - A write to the current beat takes effect on `note` the next cycle. It does not re-trigger `beat_strobe`.
- `note` is a combinational read of the registered pattern at the registered `beat`.
- `beat_strobe` = RUN && cnt==0.
  - It fires in the first RUN cycle after STOP→RUN.
  - On resume from PAUSE it fires only if the held cnt was 0.

## Timing
- Reset values: beat=0, `beat_strobe`=0, `note`=0, `note_gate`=0, `running`=0, pattern all 0.
- A control pulse sampled in cycle N sets the new state from cycle N+1.
- Each beat lasts exactly P cycles. One full loop is 8·P cycles when tempo is constant.
- Simultaneous `stop` and `play_toggle`: `stop` wins, and `play_toggle` is dropped.
- Reset mid-RUN returns to STOP on the next edge, with the pattern cleared.
- Counter width is $clog2(8·`BASE_TICKS`). No overflow is possible for legal `tempo_sel`.

## Configuration
- `SEQ_GATE_EN`: note gating behaviour.
  - Defined: `note_gate` = RUN && `note`≠0 && cnt < P/2 (P/2 by integer shift). This gives an audible articulation gap between repeated notes.
  - Undefined: `note_gate` = RUN && `note`≠0 for the full beat.
- The macro changes only the `note_gate` logic.

## Structure
- Package `sequencer_pkg` holds:
  - the state enum `seq_state_t` {STOP, RUN, PAUSE};
  - `NUM_STEPS`=8 and `STEP_W`=3;
  - the pattern array typedef.
- Sub-module `tempo_prescaler` owns cnt, the P latch and the P computation. Its inputs are run, clear and tempo_sel; its outputs are wrap (cnt==P−1), cnt_is_zero and cnt.
- The top level contains the FSM, beat counter, pattern registers and output logic.

## Test plan
All scenarios use `BASE_TICKS`=4.
- Reset, then `sequencer_on`=1, `tempo_sel`=7, `play_toggle` → `running`=1 next cycle and `beat_strobe` every 4 cycles. Beat sequence is 0,1,…,7,0, with the wrap after 32 cycles.
- Write notes 3,0,5 to steps 0,1,2, then play at `tempo_sel`=0 → `note`=3,0,5 over consecutive 32-cycle beats.
  - `SEQ_GATE_EN` defined: `note_gate` is high for 16 cycles on steps 0 and 2 and low on step 1.
  - `SEQ_GATE_EN` undefined: `note_gate` is high for all 32 cycles on steps 0 and 2.
- In RUN at beat 2, cnt 1, `play_toggle` → beat and cnt hold in PAUSE for 10 cycles. A second `play_toggle` → resumes, and beat 3 starts 2 cycles after RUN is re-entered. No strobe is issued on resume.
- Change `tempo_sel` 7→0 mid-beat → the current beat finishes at 4 cycles and the next beat lasts 32 cycles.
- `stop` and `play_toggle` in the same cycle while RUN → STOP and beat=0. Separately, dropping `sequencer_on` while RUN → STOP with the pattern retained.
- Write to the current beat while RUN → `note` updates the next cycle, with no extra `beat_strobe`. Assert `n_rst`=0 mid-RUN → all outputs and the pattern are 0 after the edge.

Source files
------------

// File: rtl/sequencer_pkg.sv
// rtl/sequencer_pkg.sv - shared states, step constants and pattern type for beat_sequencer
package sequencer_pkg;

    typedef enum logic [1:0] {
        STOP  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2
    } seq_state_t;

    localparam int NUM_STEPS      = 8;
    localparam int STEP_W         = 3;
    localparam int PATTERN_NOTE_W = 4;

    typedef logic [PATTERN_NOTE_W-1:0] pattern_t [NUM_STEPS];

endpackage

// File: rtl/tempo_prescaler.sv
// rtl/tempo_prescaler.sv - beat tick counter with latched period P = BASE_TICKS * (8 - tempo_sel)
module tempo_prescaler #(
    parameter int  BASE_TICKS = 1_000_000,
    localparam int CW         = $clog2(8 * BASE_TICKS)
) (
    input  logic          clk,
    input  logic          n_rst,
    input  logic          run,
    input  logic          clear,
    input  logic [2:0]    tempo_sel,
    output logic          wrap,
    output logic          cnt_is_zero,
    output logic [CW-1:0] cnt,
    output logic [CW:0]   period
);

    logic [3:0]  mult;
    logic [CW:0] p_new;
    logic [CW:0] p_reg;
    logic [CW:0] p_eff;

    assign mult        = 4'd8 - {1'b0, tempo_sel};
    assign p_new       = (CW+1)'(BASE_TICKS) * (CW+1)'(mult);
    assign cnt_is_zero = (cnt == '0);

    // The first cycle of a beat already runs on the freshly latched tempo,
    // so the latch and the wrap compare agree even when P is a single cycle.
    assign p_eff  = (run && cnt_is_zero) ? p_new : p_reg;
    assign period = p_eff;
    assign wrap   = run && (cnt == CW'(p_eff - 1'b1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cnt   <= '0;
            p_reg <= (CW+1)'(8 * BASE_TICKS);
        end else if (clear) begin
            cnt   <= '0;
            p_reg <= p_new;
        end else if (run) begin
            cnt <= wrap ? '0 : cnt + 1'b1;
            if (cnt_is_zero) begin
                p_reg <= p_new;
            end
        end
    end

endmodule

// File: rtl/beat_sequencer.sv
// rtl/beat_sequencer.sv - 8-step beat sequencer: FSM, beat counter, pattern store, note playback
// SEQ_GATE_EN: when defined, note_gate sounds only during the first half of each beat.
module beat_sequencer
    import sequencer_pkg::*;
#(
    parameter int  NOTE_W     = 4,
    parameter int  BASE_TICKS = 1_000_000,
    localparam int CW         = $clog2(8 * BASE_TICKS)
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sequencer_on,
    input  logic              play_toggle,
    input  logic              stop,
    input  logic [2:0]        tempo_sel,
    input  logic              wr_en,
    input  logic [2:0]        wr_beat,
    input  logic [NOTE_W-1:0] wr_note,
    output logic [2:0]        beat,
    output logic              beat_strobe,
    output logic [NOTE_W-1:0] note,
    output logic              note_gate,
    output logic              running
);

    seq_state_t state;
    seq_state_t next_state;

    logic              wrap;
    logic              cnt_is_zero;
    logic [CW-1:0]     cnt;
    logic [CW:0]       period;
    logic              clear;
    logic [NOTE_W-1:0] pattern [NUM_STEPS];

    // stop outranks play_toggle, and leaving sequencer mode outranks both.
    always_comb begin
        next_state = state;
        if (!sequencer_on || stop) begin
            next_state = STOP;
        end else if (play_toggle) begin
            case (state)
                STOP:    next_state = RUN;
                RUN:     next_state = PAUSE;
                PAUSE:   next_state = RUN;
                default: next_state = STOP;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state <= STOP;
        end else begin
            state <= next_state;
        end
    end

    assign running = (state == RUN);
    assign clear   = (next_state == STOP);

    tempo_prescaler #(
        .BASE_TICKS(BASE_TICKS)
    ) u_prescaler (
        .clk        (clk),
        .n_rst      (n_rst),
        .run        (running),
        .clear      (clear),
        .tempo_sel  (tempo_sel),
        .wrap       (wrap),
        .cnt_is_zero(cnt_is_zero),
        .cnt        (cnt),
        .period     (period)
    );

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            beat <= '0;
        end else if (clear) begin
            beat <= '0;
        end else if (wrap) begin
            beat <= beat + 3'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_STEPS; i++) begin
                pattern[i] <= '0;
            end
        end else if (wr_en) begin
            pattern[wr_beat] <= wr_note;
        end
    end

    assign note        = pattern[beat];
    assign beat_strobe = running && cnt_is_zero;

`ifdef SEQ_GATE_EN
    assign note_gate = running && (note != '0) && (cnt < period[CW:1]);
`else
    logic unused_gate_inputs;
    assign unused_gate_inputs = ^{cnt, period};
    assign note_gate = running && (note != '0);
`endif

endmodule
